de_arbiter: RTL and testbench
=============================

# de_arbiter

Two-master arbiter for the drawing-engine (de_*) memory port. It shares one downstream de_* port between two drawing cells, for example the dithering cell and a second fill/copy cell. Each cell keeps its own de_req/de_ack handshake unchanged. Arbitration is round-robin. A grant is held while its master keeps de_req high, up to BURST_MAX beats, then yields if the other master is waiting. Grant switches happen only on beat boundaries, so the downstream slave never sees a request change under it.

## Interface
- BURST_MAX, 16, beats (acked transfers) a master may take per grant before yielding to a waiting master; 0 = unlimited.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- m0_de_req, m1_de_req  in  1  master transfer request, held until acked.
- m0_de_addr, m1_de_addr  in  18  master word address.
- m0_de_nbyte, m1_de_nbyte  in  4  master active-low byte lane mask.
- m0_de_rnw, m1_de_rnw  in  1  master read-not-write.
- m0_de_w_data, m1_de_w_data  in  32  master write data.
- m0_de_ack, m1_de_ack  out  1  beat accepted, routed to the granted master only.
- m0_de_r_data, m1_de_r_data  out  32  read data, broadcast copy of de_r_data.
- de_req  out  1  downstream request.
- de_ack  in  1  downstream beat accept.
- de_addr  out  18  downstream address.
- de_nbyte  out  4  downstream byte mask.
- de_rnw  out  1  downstream read-not-write.
- de_w_data  out  32  downstream write data.
- de_r_data  in  32  downstream read data.
- grant  out  2  one-hot current owner: bit0 = m0, bit1 = m1; 00 = idle.

## Operation
- States: IDLE, OWN0, OWN1. Registers are the state, `last` (last owner, 1 bit) and `beats` (counter, wide enough for BURST_MAX).
- Downstream outputs are a combinational mux of the owner's signals, selected by the registered state.
  - In IDLE: de_req=0, de_addr=0, de_nbyte=4'b1111, de_rnw=1, de_w_data=0.
- mX_de_ack = de_ack & (state==OWNX). A non-owner sees ack=0 and stalls with its request held.
- IDLE transitions:
  - Only one request pending → grant it.
  - Both pending → grant the master that is not `last`.
- OWNX, evaluated at each posedge, first match wins:
  1. mX_de_req=0 → go to OWN(other) if the other request is high, else IDLE.
  2. de_ack=1, BURST_MAX≠0, beats+1==BURST_MAX, other request high → go to OWN(other).
  3. de_ack=1 → beats+1; hold grant.
  4. Otherwise hold.
- On any grant change or entry to IDLE: beats←0; `last`←the master being left.
- If the limit is reached with no other request pending, the owner keeps the grant and beats saturates at BURST_MAX.
- A grant never changes in a cycle where the owner's request is high and de_ack is low.

## Timing
- Reset values: state IDLE, `last`=1 (so m0 wins the first tie), beats=0.
  - Outputs: grant=00, de_req=0, m0_de_ack=m1_de_ack=0, de_addr=0, de_nbyte=4'b1111, de_rnw=1, de_w_data=0.
- Reset asserted mid-burst: de_req and both acks drop in the same cycle, before any clock edge; the in-flight beat is abandoned.
- Grant latency: a request first sampled high in IDLE at edge N sees grant and de_req high after edge N. With a 1-cycle slave, its first ack comes in the cycle after that edge.
- Handover latency: zero idle cycles. The new owner drives de_req in the cycle after the last ack to the previous owner.
- De-ack and data paths are combinational through the mux; no added pipeline stage.

## Test plan
- Reset with m0_de_req=1, addr=0x00010 → grant=00 and de_req=0 during reset; after release, grant=01 one edge later and de_addr=0x00010.
- Both requests high at once from IDLE after reset → m0 granted first. After m0 drops req, m1 is granted next edge, with no idle cycle between them.
- BURST_MAX=4, both requesting continuously, slave acks every cycle → ownership alternates every 4 acks: m0 ×4, m1 ×4, m0 ×4. Non-owner ack stays 0 throughout.
- BURST_MAX=4, only m1 requesting, 10 beats → m1 holds the grant for all 10 acks; beats saturates at 4; grant stays 10.
- Slave delays ack 3 cycles while the limit is reached and m0 is waiting → grant and de_addr stay stable until de_ack, then switch on the next edge.
- Assert rst while OWN1 with de_req=1 → de_req=0, m1_de_ack=0 and grant=00 within the same cycle; after release, m0 wins a tie (`last`=1).

Source files
------------

// File: rtl/de_arbiter.sv
// de_arbiter: round-robin arbiter sharing one drawing-engine (de_*) memory
// port between two masters. A master keeps the grant while it holds
// de_req, up to BURST_MAX acked beats, then yields if the other master is
// waiting. Grant changes only happen on a clock edge where the owner
// either dropped its request or took an ack, so the slave never sees a
// request swapped under it.
//
// Ports:
//   clk, rst             system clock, async active-high reset
//   mX_de_req/addr/...   master-side request bundles (X = 0, 1)
//   mX_de_ack            beat accept, only to the current owner
//   mX_de_r_data         broadcast copy of de_r_data
//   de_*                 downstream port (combinational mux of the owner)
//   grant                one-hot owner: bit0 = m0, bit1 = m1, 00 = idle
module de_arbiter #(
  parameter int unsigned BURST_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_de_req,
  input  logic [17:0] m0_de_addr,
  input  logic [3:0]  m0_de_nbyte,
  input  logic        m0_de_rnw,
  input  logic [31:0] m0_de_w_data,
  output logic        m0_de_ack,
  output logic [31:0] m0_de_r_data,
  input  logic        m1_de_req,
  input  logic [17:0] m1_de_addr,
  input  logic [3:0]  m1_de_nbyte,
  input  logic        m1_de_rnw,
  input  logic [31:0] m1_de_w_data,
  output logic        m1_de_ack,
  output logic [31:0] m1_de_r_data,
  output logic        de_req,
  input  logic        de_ack,
  output logic [17:0] de_addr,
  output logic [3:0]  de_nbyte,
  output logic        de_rnw,
  output logic [31:0] de_w_data,
  input  logic [31:0] de_r_data,
  output logic [1:0]  grant
);

  // Counter must hold BURST_MAX itself, since it saturates there.
  localparam int BW = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_last;
  logic [BW-1:0] r_beats;

  logic          w_own_is1;
  logic          w_own_req;
  logic          w_oth_req;
  logic [31:0]   w_beats_nxt;
  logic          w_at_limit;
  logic          w_can_inc;

  assign w_own_is1   = (r_state == OWN1);
  assign w_own_req   = w_own_is1 ? m1_de_req : m0_de_req;
  assign w_oth_req   = w_own_is1 ? m0_de_req : m1_de_req;
  assign w_beats_nxt = 32'(r_beats) + 32'd1;
  // ">=" rather than "==" so a saturated owner still yields once the other
  // master starts waiting; the two agree while the counter is below the limit.
  assign w_at_limit  = (BURST_MAX != 0) && (w_beats_nxt >= BURST_MAX);
  assign w_can_inc   = (BURST_MAX != 0) && (w_beats_nxt <= BURST_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_beats <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_beats <= '0;
          if (m0_de_req && (!m1_de_req || r_last)) begin
            r_state <= OWN0;
          end else if (m1_de_req) begin
            r_state <= OWN1;
          end
        end
        OWN0, OWN1: begin
          if (!w_own_req || (de_ack && w_at_limit && w_oth_req)) begin
            r_last  <= w_own_is1;
            r_beats <= '0;
            if (w_oth_req) begin
              r_state <= w_own_is1 ? OWN0 : OWN1;
            end else begin
              r_state <= IDLE;
            end
          end else if (de_ack && w_can_inc) begin
            r_beats <= BW'(w_beats_nxt);
          end
        end
        default: begin
          r_state <= IDLE;
          r_beats <= '0;
        end
      endcase
    end
  end

  always_comb begin
    de_req    = 1'b0;
    de_addr   = '0;
    de_nbyte  = 4'b1111;
    de_rnw    = 1'b1;
    de_w_data = '0;
    case (r_state)
      OWN0: begin
        de_req    = m0_de_req;
        de_addr   = m0_de_addr;
        de_nbyte  = m0_de_nbyte;
        de_rnw    = m0_de_rnw;
        de_w_data = m0_de_w_data;
      end
      OWN1: begin
        de_req    = m1_de_req;
        de_addr   = m1_de_addr;
        de_nbyte  = m1_de_nbyte;
        de_rnw    = m1_de_rnw;
        de_w_data = m1_de_w_data;
      end
      default: ;
    endcase
  end

  assign m0_de_ack    = de_ack & (r_state == OWN0);
  assign m1_de_ack    = de_ack & (r_state == OWN1);
  assign m0_de_r_data = de_r_data;
  assign m1_de_r_data = de_r_data;
  assign grant        = {r_state == OWN1, r_state == OWN0};

endmodule

// File: tb/tb_de_arbiter.sv
module tb_de_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_de_req = 1'b0, m1_de_req = 1'b0;
  logic [17:0] m0_de_addr = 18'h00010, m1_de_addr = 18'h2ABCD;
  logic [3:0]  m0_de_nbyte = 4'b0000, m1_de_nbyte = 4'b1010;
  logic        m0_de_rnw = 1'b0, m1_de_rnw = 1'b1;
  logic [31:0] m0_de_w_data = 32'h1111_0000, m1_de_w_data = 32'h2222_0000;
  logic        m0_de_ack, m1_de_ack;
  logic [31:0] m0_de_r_data, m1_de_r_data;
  logic        de_req;
  logic        de_ack = 1'b0;
  logic [17:0] de_addr;
  logic [3:0]  de_nbyte;
  logic        de_rnw;
  logic [31:0] de_w_data;
  logic [31:0] de_r_data = 32'h0;
  logic [1:0]  grant;

  int n_cmp = 0;
  int n_bad = 0;

  de_arbiter #(.BURST_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .m0_de_req(m0_de_req), .m0_de_addr(m0_de_addr), .m0_de_nbyte(m0_de_nbyte),
    .m0_de_rnw(m0_de_rnw), .m0_de_w_data(m0_de_w_data),
    .m0_de_ack(m0_de_ack), .m0_de_r_data(m0_de_r_data),
    .m1_de_req(m1_de_req), .m1_de_addr(m1_de_addr), .m1_de_nbyte(m1_de_nbyte),
    .m1_de_rnw(m1_de_rnw), .m1_de_w_data(m1_de_w_data),
    .m1_de_ack(m1_de_ack), .m1_de_r_data(m1_de_r_data),
    .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr), .de_nbyte(de_nbyte),
    .de_rnw(de_rnw), .de_w_data(de_w_data), .de_r_data(de_r_data),
    .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with m0 already requesting
    m0_de_req = 1'b1;
    #2;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_de_req", 64'(de_req), 64'h0);
    chk("rst_addr", 64'(de_addr), 64'h0);
    chk("rst_nbyte", 64'(de_nbyte), 64'hF);
    chk("rst_rnw", 64'(de_rnw), 64'h1);
    chk("rst_wdata", 64'(de_w_data), 64'h0);
    de_ack = 1'b1;
    #1;
    chk("rst_acks", 64'({m1_de_ack, m0_de_ack}), 64'h0);
    de_ack = 1'b0;
    tick();
    rst = 1'b0;
    chk("post_rst_idle", 64'(grant), 64'h0);
    tick();
    chk("lat_grant", 64'(grant), 64'h1);
    chk("lat_de_req", 64'(de_req), 64'h1);
    chk("lat_addr", 64'(de_addr), 64'h00010);
    chk("lat_wdata", 64'(de_w_data), 64'h1111_0000);
    chk("lat_rnw", 64'(de_rnw), 64'h0);
    de_ack = 1'b1;
    de_r_data = 32'hDEAD_BEEF;
    #1;
    chk("ack_route", 64'({m1_de_ack, m0_de_ack}), 64'h1);
    chk("rdata_bcast", 64'({m0_de_r_data, m1_de_r_data}), 64'hDEAD_BEEF_DEAD_BEEF);
    de_ack = 1'b0;
    m0_de_req = 1'b0;
    tick();
    chk("drop_idle", 64'(grant), 64'h0);

    // tie after reset goes to m0, then zero-gap handover to m1
    rst = 1'b1;
    #1;
    rst = 1'b0;
    m0_de_req = 1'b1;
    m1_de_req = 1'b1;
    tick();
    chk("tie_m0", 64'(grant), 64'h1);
    de_ack = 1'b1;
    #1;
    chk("tie_nonowner_ack", 64'(m1_de_ack), 64'h0);
    de_ack = 1'b0;
    m0_de_req = 1'b0;
    tick();
    chk("handover_grant", 64'(grant), 64'h2);
    chk("handover_req", 64'(de_req), 64'h1);
    chk("handover_addr", 64'(de_addr), 64'h2ABCD);
    chk("handover_nbyte", 64'(de_nbyte), 64'hA);
    m1_de_req = 1'b0;
    tick();
    chk("handover_idle", 64'(grant), 64'h0);

    // continuous contention, BURST_MAX=4: m0 x4, m1 x4, m0 x4
    m0_de_req = 1'b1;
    m1_de_req = 1'b1;
    tick();
    de_ack = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (((i / 4) % 2) == 0) begin
        chk($sformatf("rr_grant_%0d", i), 64'(grant), 64'h1);
        chk($sformatf("rr_acks_%0d", i), 64'({m1_de_ack, m0_de_ack}), 64'h1);
      end else begin
        chk($sformatf("rr_grant_%0d", i), 64'(grant), 64'h2);
        chk($sformatf("rr_acks_%0d", i), 64'({m1_de_ack, m0_de_ack}), 64'h2);
      end
      tick();
    end
    chk("rr_after12", 64'(grant), 64'h2);
    de_ack = 1'b0;
    m0_de_req = 1'b0;
    m1_de_req = 1'b0;
    tick();
    chk("rr_idle", 64'(grant), 64'h0);

    // lone m1 for 10 beats: never yields, counter saturates
    m1_de_req = 1'b1;
    tick();
    de_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("solo_grant_%0d", i), 64'(grant), 64'h2);
      chk($sformatf("solo_ack_%0d", i), 64'(m1_de_ack), 64'h1);
      tick();
    end
    chk("solo_beats_sat", 64'(dut.r_beats), 64'd4);
    de_ack = 1'b0;
    m1_de_req = 1'b0;
    tick();
    chk("solo_idle", 64'(grant), 64'h0);

    // limit reached with m0 waiting, slave stalls 3 cycles
    m1_de_req = 1'b1;
    tick();
    de_ack = 1'b1;
    repeat (3) tick();
    m0_de_req = 1'b1;
    de_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_grant_%0d", i), 64'(grant), 64'h2);
      chk($sformatf("stall_addr_%0d", i), 64'(de_addr), 64'h2ABCD);
    end
    de_ack = 1'b1;
    #1;
    chk("stall_final_ack", 64'(m1_de_ack), 64'h1);
    tick();
    de_ack = 1'b0;
    chk("stall_switch_grant", 64'(grant), 64'h1);
    chk("stall_switch_addr", 64'(de_addr), 64'h00010);

    // reset while m1 owns with a live request
    m0_de_req = 1'b0;
    tick();
    chk("pre_rst_own1", 64'(grant), 64'h2);
    de_ack = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_de_req", 64'(de_req), 64'h0);
    chk("midrst_m1_ack", 64'(m1_de_ack), 64'h0);
    chk("midrst_grant", 64'(grant), 64'h0);
    de_ack = 1'b0;
    rst = 1'b0;
    m0_de_req = 1'b1;
    tick();
    chk("post_midrst_tie", 64'(grant), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
